// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI mode-0 slave giving access to seven 8-bit config registers
// and a read-only ID byte at address 7.
//
// Frame format (cs low): one command byte, then any number of data bytes.
//   cmd[7]   = 1 read, 0 write
//   cmd[6:3] = must be 0, otherwise the frame is ignored and err_flag sets
//   cmd[2:0] = start address; it auto-increments (mod 8) after each data byte
//
// Ports:
//   sclk     - SPI clock from master (mode 0: sample on rise, shift on fall)
//   reset    - asynchronous, active-high reset
//   cs       - active-low chip select; high aborts/ends the frame
//   mosi     - serial data in, MSB first
//   miso     - serial data out, MSB first; 0 while cs is high
//   cfg_out  - registers 0..6, reg n at [8n+7:8n]
//   err_flag - sticky protocol error, cleared by the next valid command
//   busy     - !cs
module spi_reg_ctrl #(
  parameter logic [7:0] ID_VALUE = 8'hA5
) (
  input  logic        sclk,
  input  logic        reset,
  input  logic        cs,
  input  logic        mosi,
  output logic        miso,
  output logic [55:0] cfg_out,
  output logic        err_flag,
  output logic        busy
);

  typedef enum logic [1:0] {ST_CMD, ST_RD, ST_WR, ST_IGN} state_e;

  // Per-frame state is cleared whenever cs is high; register contents,
  // err_flag, tx_byte and address survive between frames.
  logic frame_clr;
  assign frame_clr = reset | cs;

  state_e          state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      rx_q, rx_d;
  logic            miso_q, miso_d;
  logic [6:0][7:0] regs_q, regs_d;
  logic            err_q, err_d;
  logic [7:0]      tx_q, tx_d;
  logic [2:0]      addr_q, addr_d;

  logic [7:0]      byte_in;
  logic            byte_done;
  logic [7:0][7:0] rd_map;
  logic [2:0]      addr_nxt;
  logic [7:0]      tx_sel;

  // The byte completes on the 8th rising edge: the current mosi is its LSB.
  assign byte_in   = {rx_q[6:0], mosi};
  assign byte_done = (bitcnt_q == 3'd7);
  assign rd_map    = {ID_VALUE, regs_q};
  assign addr_nxt  = addr_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q + 3'd1;
    rx_d     = byte_in;
    regs_d   = regs_q;
    err_d    = err_q;
    tx_d     = tx_q;
    addr_d   = addr_q;
    if (byte_done) begin
      case (state_q)
        ST_CMD: begin
          if (byte_in[6:3] != 4'd0) begin
            state_d = ST_IGN;
            err_d   = 1'b1;
          end else begin
            state_d = byte_in[7] ? ST_RD : ST_WR;
            addr_d  = byte_in[2:0];
            err_d   = 1'b0;
            tx_d    = rd_map[byte_in[2:0]];
          end
        end
        ST_RD: begin
          addr_d = addr_nxt;
          tx_d   = rd_map[addr_nxt];
        end
        ST_WR: begin
          if (addr_q == 3'd7) err_d = 1'b1;
          for (int i = 0; i < 7; i++)
            if (addr_q == 3'(i)) regs_d[i] = byte_in;
          addr_d = addr_nxt;
          // Next address differs from the one just written, so the
          // pre-write map is still the right source.
          tx_d   = rd_map[addr_nxt];
        end
        default: ;
      endcase
    end
  end

  // Transmit source depends on the frame phase. MSB of each byte goes out on
  // the falling edge that follows the previous byte's 8th rise; the very first
  // bit of a frame is the cleared miso flop, i.e. 0.
  always_comb begin
    case (state_q)
      ST_CMD:       tx_sel = {7'b0, err_q};
      ST_RD, ST_WR: tx_sel = tx_q;
      default:      tx_sel = 8'h00;
    endcase
    miso_d = tx_sel[3'd7 - bitcnt_q];
  end

  always_ff @(posedge sclk or posedge frame_clr) begin
    if (frame_clr) begin
      state_q  <= ST_CMD;
      bitcnt_q <= 3'd0;
      rx_q     <= 8'h00;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      rx_q     <= rx_d;
    end
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      regs_q <= '0;
      err_q  <= 1'b0;
      tx_q   <= 8'h00;
      addr_q <= 3'd0;
    end else begin
      regs_q <= regs_d;
      err_q  <= err_d;
      tx_q   <= tx_d;
      addr_q <= addr_d;
    end
  end

  always_ff @(negedge sclk or posedge frame_clr) begin
    if (frame_clr) miso_q <= 1'b0;
    else           miso_q <= miso_d;
  end

  assign miso     = cs ? 1'b0 : miso_q;
  assign cfg_out  = regs_q;
  assign err_flag = err_q;
  assign busy     = ~cs;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: the bench acts as SPI master, pushes the
// expected miso byte for every full byte it sends into a queue and compares
// against what it actually shifted in.
module tb_spi_reg_ctrl;

  logic        sclk, reset, cs, mosi;
  logic        miso;
  logic [55:0] cfg_out;
  logic        err_flag, busy;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  spi_reg_ctrl #(.ID_VALUE(8'hA5)) dut (
    .sclk(sclk), .reset(reset), .cs(cs), .mosi(mosi),
    .miso(miso), .cfg_out(cfg_out), .err_flag(err_flag), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Send n MSB-first bits of b; miso sampled 1 time unit before each rise.
  task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi  = b[i];
      #4 rx[i] = miso;
      #1 sclk = 1'b1;
      #5 sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] b, input string tag);
    logic [7:0] rx;
    send_bits(b, 8, rx);
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s: observed %h expected <scoreboard empty>", tag, rx);
    end else begin
      chk(tag, {56'h0, rx}, {56'h0, exp_q.pop_front()});
    end
  endtask

  task automatic frame_start();
    cs = 1'b0;
    #5;
  endtask

  task automatic frame_end();
    #5 cs = 1'b1;
    #5;
  endtask

  initial begin
    logic [7:0] junk;
    sclk = 1'b0; mosi = 1'b0; cs = 1'b1; reset = 1'b1;
    #10;
    chk("rst_cfg",  {8'h0, cfg_out}, 64'h0);
    chk("rst_err",  {63'h0, err_flag}, 64'h0);
    chk("rst_miso", {63'h0, miso}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    reset = 1'b0;
    #10;

    // Write burst 0x11, 0x22 to reg2/reg3
    frame_start();
    chk("busy_low", {63'h0, busy}, 64'h1);
    exp_q.push_back(8'h00); xfer(8'h02, "wb_cmd");
    exp_q.push_back(8'h00); xfer(8'h11, "wb_d0");
    exp_q.push_back(8'h00); xfer(8'h22, "wb_d1");
    frame_end();
    chk("wb_cfg",  {8'h0, cfg_out}, {8'h0, 56'h00_00_00_22_11_00_00});
    chk("wb_err",  {63'h0, err_flag}, 64'h0);
    chk("cs_miso", {63'h0, miso}, 64'h0);
    chk("busy_hi", {63'h0, busy}, 64'h0);

    // Preload reg6 and reg0
    frame_start();
    exp_q.push_back(8'h00); xfer(8'h06, "pl6_cmd");
    exp_q.push_back(8'h00); xfer(8'h5C, "pl6_d");
    frame_end();
    frame_start();
    exp_q.push_back(8'h00); xfer(8'h00, "pl0_cmd");
    exp_q.push_back(8'h00); xfer(8'h3E, "pl0_d");
    frame_end();

    // Read burst across the 7->0 wrap
    frame_start();
    exp_q.push_back(8'h00); xfer(8'h86, "rd_cmd");
    exp_q.push_back(8'h5C); xfer(8'hFF, "rd_r6");
    exp_q.push_back(8'hA5); xfer(8'hFF, "rd_id");
    exp_q.push_back(8'h3E); xfer(8'hFF, "rd_r0");
    frame_end();
    chk("rd_cfg", {8'h0, cfg_out}, {8'h0, 56'h5C_00_00_22_11_00_3E});
    chk("rd_err", {63'h0, err_flag}, 64'h0);

    // Invalid command: ignored frame
    frame_start();
    exp_q.push_back(8'h00); xfer(8'h48, "inv_cmd");
    exp_q.push_back(8'h00); xfer(8'hFF, "inv_d");
    frame_end();
    chk("inv_cfg", {8'h0, cfg_out}, {8'h0, 56'h5C_00_00_22_11_00_3E});
    chk("inv_err", {63'h0, err_flag}, 64'h1);
    frame_start();
    exp_q.push_back(8'h01); xfer(8'h80, "aft_cmd");
    chk("aft_err", {63'h0, err_flag}, 64'h0);
    exp_q.push_back(8'h3E); xfer(8'h00, "aft_r0");
    frame_end();

    // Write to the ID address
    frame_start();
    exp_q.push_back(8'h00); xfer(8'h07, "wid_cmd");
    exp_q.push_back(8'hA5); xfer(8'h99, "wid_d");
    frame_end();
    chk("wid_cfg", {8'h0, cfg_out}, {8'h0, 56'h5C_00_00_22_11_00_3E});
    chk("wid_err", {63'h0, err_flag}, 64'h1);

    // Partial (invalid) command byte leaves a set err_flag alone
    frame_start();
    send_bits(8'h48, 5, junk);
    frame_end();
    chk("pcmd_err", {63'h0, err_flag}, 64'h1);

    // Partial data byte: no write
    frame_start();
    exp_q.push_back(8'h01); xfer(8'h01, "pd_cmd");
    send_bits(8'hFF, 5, junk);
    frame_end();
    chk("pd_cfg", {8'h0, cfg_out}, {8'h0, 56'h5C_00_00_22_11_00_3E});
    chk("pd_err", {63'h0, err_flag}, 64'h0);

    // Reset in the middle of a write to reg3
    frame_start();
    exp_q.push_back(8'h00); xfer(8'h03, "pw_cmd");
    exp_q.push_back(8'h22); xfer(8'h77, "pw_d");
    frame_end();
    chk("pw_cfg", {8'h0, cfg_out}, {8'h0, 56'h5C_00_00_77_11_00_3E});
    frame_start();
    exp_q.push_back(8'h00); xfer(8'h03, "rm_cmd");
    send_bits(8'hEE, 4, junk);
    reset = 1'b1;
    #5;
    chk("rm_cfg",  {8'h0, cfg_out}, 64'h0);
    chk("rm_err",  {63'h0, err_flag}, 64'h0);
    chk("rm_miso", {63'h0, miso}, 64'h0);
    reset = 1'b0;
    #5;
    // cs still low: next rise is bit 0 of a fresh command
    exp_q.push_back(8'h00); xfer(8'h01, "post_cmd");
    exp_q.push_back(8'h00); xfer(8'hAB, "post_d");
    frame_end();
    chk("post_cfg", {8'h0, cfg_out}, {8'h0, 56'h00_00_00_00_00_AB_00});
    chk("post_err", {63'h0, err_flag}, 64'h0);
    chk("sb_empty", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have parameter ID_VALUE, default 8'hA5, read-only identification byte returned at address 7.
REQ-002 SHALL have port sclk, input, 1: SPI clock from master, mode 0 (CPOL=0, CPHA=0).
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port cs, input, 1: chip select, active low, frames one transaction.
REQ-005 SHALL have port mosi, input, 1: master to slave serial data, MSB first.
REQ-006 SHALL have port miso, output, 1: slave to master serial data, MSB first.
REQ-007 SHALL have port cfg_out, output, 56: registers 0..6 concatenated, reg n at bits [8n+7:8n].
REQ-008 SHALL have port err_flag, output, 1: sticky protocol-error flag.
REQ-009 SHALL have port busy, output, 1: combinational !cs.

Function
REQ-010 SHALL sample mosi on posedge sclk only while cs is low, shifting it into an 8-bit receive register, and SHALL count bits 0..7 with wrap.
REQ-011 SHALL clear the bit counter, the receive register and the miso register, and SHALL set the frame state to CMD, asynchronously whenever cs is high, without affecting registers or err_flag.
REQ-012 SHALL implement frame states CMD, RD, WR and IGN.
REQ-013 CMD: the first byte is the command, where bit7 = 1 for read and 0 for write, bits[6:3] must be 0, and bits[2:0] give the start address.
REQ-014 SHALL leave CMD, on the 8th posedge of a valid command byte, for RD or WR, SHALL latch the address, and SHALL clear err_flag.
REQ-015 SHALL, on the 8th posedge of a command byte with bits[6:3] != 0, go to IGN and set err_flag.
REQ-016 IGN: SHALL perform no register writes, SHALL hold miso at 0, and SHALL exit only when cs goes high.
REQ-017 SHALL define the transmit byte as {7'b0, err_flag} during CMD, the tx_byte register during RD and WR, and 8'h00 during IGN.
REQ-018 SHALL update miso on negedge sclk while cs is low to transmit_byte[7 - bitcount]; the first bit of every frame is therefore 0.
REQ-019 SHALL, on the 8th posedge of the command byte or of any data byte, load tx_byte with the value at the address for the next data byte: ID_VALUE at address 7, otherwise reg[address].
REQ-020 WR: SHALL, on the 8th posedge of each data byte, write {rx[6:0], mosi} to reg[address] when address != 7.
REQ-021 WR: a data byte addressed to 7 SHALL be discarded and SHALL set err_flag.
REQ-022 WR: miso SHALL shift out the pre-write contents of the addressed register.
REQ-023 RD: miso SHALL shift out reg[address] (ID_VALUE at 7), and received mosi data SHALL be ignored.
REQ-024 SHALL increment the address by 1 modulo 8 after each complete data byte in RD and WR (burst; 7 wraps to 0).
REQ-025 SHALL discard a partial byte (fewer than 8 posedges before cs rises): no write, no address change, no err_flag change.
REQ-026 SHALL drive cfg_out directly from register flops, so a write is visible immediately after the 8th posedge.
REQ-027 SHALL force miso to 0 while cs is high.

Reset
REQ-028 reset SHALL asynchronously clear registers 0..6 to 8'h00, err_flag to 0, the miso register to 0, the bit counter to 0, tx_byte to 0, the address to 0 and the state to CMD.
REQ-029 SHALL give reset priority over cs and sclk activity.
REQ-030 reset asserted mid-frame SHALL abort the frame with no partial write.
REQ-031 After reset is released mid-frame, SHALL treat the next posedge as bit 0 of a command byte.

Verification
REQ-032 Write burst: cs low, send 8'h02, 8'h11, 8'h22, cs high -> cfg_out[23:16]=8'h11, cfg_out[31:24]=8'h22, err_flag=0.
REQ-033 Read burst across wrap: preload reg6=8'h5C, reg0=8'h3E; send 8'h86 then 3 dummy bytes -> miso bytes 8'h00, 8'h5C, ID_VALUE (8'hA5), 8'h3E.
REQ-034 Invalid command: send 8'h48, 8'hFF -> no cfg_out change, miso all 0, err_flag=1; next frame's first byte on miso = 8'h01, and err_flag=0 after its valid command.
REQ-035 Write to ID: send 8'h07, 8'h99 -> cfg_out unchanged, err_flag=1, miso during data byte = 8'hA5.
REQ-036 Partial byte: send 8'h01 then 5 bits of 8'hFF, cs high -> reg1 unchanged, err_flag unchanged.
REQ-037 Reset mid-write: assert reset after 4 data bits of a write to reg3 holding 8'h77 -> reg3=8'h00, no write; a following frame behaves normally.
